// File: rtl/rs_cam_issue_queue.sv
// -----------------------------------------------------------------------------
// rs_cam_issue_queue
//   Reservation station with NUM_ENTRIES slots. Waiting source operands are woken
//   by a CAM match against NUM_CDB result buses. The oldest eligible entry is
//   selected for issue using an age matrix.
//
//   Optional feature macro: RS_WAKEUP_BYPASS_EN
//     defined   : a CDB match in the current cycle already makes an entry eligible,
//                 and its issue value is taken directly from cdb_value.
//     undefined : a woken entry becomes eligible one cycle after the broadcast.
//
//   Ports
//     clk, reset          clock, synchronous active-high reset
//     flush               drop every entry (mispredict recovery)
//     load_*              dispatch side valid/ready, opcode, dest tag, source operands
//     cdb_valid/tag/value result broadcast buses, channel k at [k*W +: W]
//     issue_*             FU side valid/ready, opcode, dest tag, operand values
//     count               number of occupied entries
// -----------------------------------------------------------------------------
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif
`ifndef XLEN
`define XLEN 32
`endif

module rs_cam_issue_queue #(
    parameter int NUM_ENTRIES = 8,
    parameter int NUM_CDB     = 4,
    parameter int TAG_W       = `ROB_TAG_LEN,
    parameter int DATA_W      = `XLEN,
    parameter int OP_W        = 5
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              flush,
    input  logic                              load_valid,
    output logic                              load_ready,
    input  logic [OP_W-1:0]                   load_op,
    input  logic [TAG_W-1:0]                  load_tag,
    input  logic [TAG_W-1:0]                  load_src1_tag,
    input  logic [TAG_W-1:0]                  load_src2_tag,
    input  logic                              load_src1_rdy,
    input  logic                              load_src2_rdy,
    input  logic [DATA_W-1:0]                 load_src1_val,
    input  logic [DATA_W-1:0]                 load_src2_val,
    input  logic [NUM_CDB-1:0]                cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]          cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0]         cdb_value,
    output logic                              issue_valid,
    input  logic                              issue_ready,
    output logic [OP_W-1:0]                   issue_op,
    output logic [TAG_W-1:0]                  issue_tag,
    output logic [DATA_W-1:0]                 issue_src1_val,
    output logic [DATA_W-1:0]                 issue_src2_val,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]  count
);
    localparam int CW = $clog2(NUM_ENTRIES + 1);
    localparam int IW = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    logic [NUM_ENTRIES-1:0] valid_r, s1_rdy_r, s2_rdy_r;
    logic [OP_W-1:0]        op_r     [NUM_ENTRIES];
    logic [TAG_W-1:0]       tag_r    [NUM_ENTRIES];
    logic [TAG_W-1:0]       s1_tag_r [NUM_ENTRIES];
    logic [TAG_W-1:0]       s2_tag_r [NUM_ENTRIES];
    logic [DATA_W-1:0]      s1_val_r [NUM_ENTRIES];
    logic [DATA_W-1:0]      s2_val_r [NUM_ENTRIES];
    // older_r[j][i] set means entry j was allocated before entry i
    logic [NUM_ENTRIES-1:0] older_r  [NUM_ENTRIES];
    logic [CW-1:0]          count_r;

    logic [NUM_ENTRIES-1:0] w1_hit_s, w2_hit_s, wake1_s, wake2_s, elig_s, sel_s;
    logic [DATA_W-1:0]      w1_val_s [NUM_ENTRIES];
    logic [DATA_W-1:0]      w2_val_s [NUM_ENTRIES];
    logic                   l1_hit_s, l2_hit_s;
    logic [DATA_W-1:0]      l1_val_s, l2_val_s;
    logic [IW-1:0]          alloc_idx_s;
    logic                   issue_en_s, load_fire_s, issue_fire_s;

    // CAM lookup of one tag across all channels; lowest channel wins on duplicates
    function automatic logic [DATA_W:0] cam_lookup(
        input logic [TAG_W-1:0]          t,
        input logic [NUM_CDB-1:0]        v,
        input logic [NUM_CDB*TAG_W-1:0]  tags,
        input logic [NUM_CDB*DATA_W-1:0] vals
    );
        logic [DATA_W:0] res;
        res = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (v[k] && (tags[k*TAG_W +: TAG_W] == t)) begin
                res = {1'b1, vals[k*DATA_W +: DATA_W]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // CDB matching for stored entries and for the operands being loaded
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            {w1_hit_s[i], w1_val_s[i]} = cam_lookup(s1_tag_r[i], cdb_valid, cdb_tag, cdb_value);
            {w2_hit_s[i], w2_val_s[i]} = cam_lookup(s2_tag_r[i], cdb_valid, cdb_tag, cdb_value);
        end
        wake1_s = valid_r & ~s1_rdy_r & w1_hit_s;
        wake2_s = valid_r & ~s2_rdy_r & w2_hit_s;
        {l1_hit_s, l1_val_s} = cam_lookup(load_src1_tag, cdb_valid, cdb_tag, cdb_value);
        {l2_hit_s, l2_val_s} = cam_lookup(load_src2_tag, cdb_valid, cdb_tag, cdb_value);
    end

    // Lowest-index free entry for allocation
    always_comb begin
        alloc_idx_s = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_r[i]) begin
                alloc_idx_s = IW'(i);
            end else begin
                alloc_idx_s = alloc_idx_s;
            end
        end
    end

    // Eligibility, oldest-first select and issue data mux
    always_comb begin
        logic blocked;
        issue_en_s = !flush && !reset;
`ifdef RS_WAKEUP_BYPASS_EN
        elig_s = valid_r & (s1_rdy_r | wake1_s) & (s2_rdy_r | wake2_s);
`else
        elig_s = valid_r & s1_rdy_r & s2_rdy_r;
`endif
        issue_op       = '0;
        issue_tag      = '0;
        issue_src1_val = '0;
        issue_src2_val = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                blocked = blocked | (older_r[j][i] & elig_s[j]);
            end
            sel_s[i] = elig_s[i] & ~blocked & issue_en_s;
            if (sel_s[i]) begin
                issue_op  = issue_op  | op_r[i];
                issue_tag = issue_tag | tag_r[i];
`ifdef RS_WAKEUP_BYPASS_EN
                issue_src1_val = issue_src1_val | (s1_rdy_r[i] ? s1_val_r[i] : w1_val_s[i]);
                issue_src2_val = issue_src2_val | (s2_rdy_r[i] ? s2_val_r[i] : w2_val_s[i]);
`else
                issue_src1_val = issue_src1_val | s1_val_r[i];
                issue_src2_val = issue_src2_val | s2_val_r[i];
`endif
            end else begin
                issue_op = issue_op;
            end
        end
        issue_valid  = |sel_s;
        load_ready   = (count_r != CW'(NUM_ENTRIES));
        load_fire_s  = load_valid && load_ready && !flush && !reset;
        issue_fire_s = issue_valid && issue_ready;
        count        = count_r;
    end

    // Entry state, age matrix and occupancy count
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r  <= '0;
            s1_rdy_r <= '0;
            s2_rdy_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                op_r[i]     <= '0;
                tag_r[i]    <= '0;
                s1_tag_r[i] <= '0;
                s2_tag_r[i] <= '0;
                s1_val_r[i] <= '0;
                s2_val_r[i] <= '0;
                older_r[i]  <= '0;
            end
        end else if (flush) begin
            valid_r <= '0;
            count_r <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                older_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (wake1_s[i]) begin
                    s1_rdy_r[i] <= 1'b1;
                    s1_val_r[i] <= w1_val_s[i];
                end
                if (wake2_s[i]) begin
                    s2_rdy_r[i] <= 1'b1;
                    s2_val_r[i] <= w2_val_s[i];
                end
                if (sel_s[i] && issue_ready) begin
                    valid_r[i] <= 1'b0;
                end
            end
            if (load_fire_s) begin
                valid_r[alloc_idx_s]  <= 1'b1;
                op_r[alloc_idx_s]     <= load_op;
                tag_r[alloc_idx_s]    <= load_tag;
                s1_tag_r[alloc_idx_s] <= load_src1_tag;
                s2_tag_r[alloc_idx_s] <= load_src2_tag;
                s1_rdy_r[alloc_idx_s] <= load_src1_rdy | l1_hit_s;
                s2_rdy_r[alloc_idx_s] <= load_src2_rdy | l2_hit_s;
                s1_val_r[alloc_idx_s] <= load_src1_rdy ? load_src1_val : l1_val_s;
                s2_val_r[alloc_idx_s] <= load_src2_rdy ? load_src2_val : l2_val_s;
                for (int j = 0; j < NUM_ENTRIES; j++) begin
                    older_r[j][alloc_idx_s] <= valid_r[j];
                end
                older_r[alloc_idx_s] <= '0;
            end
            case ({load_fire_s, issue_fire_s})
                2'b10: count_r <= (count_r != CW'(NUM_ENTRIES)) ? count_r + CW'(1) : count_r;
                2'b01: count_r <= (count_r != CW'(0)) ? count_r - CW'(1) : count_r;
                default: count_r <= count_r;
            endcase
        end
    end
endmodule
